// File: rtl/class_decision_voter.sv
// Majority voter over WINDOW consecutive class codes with a valid/ready decision output.
// Optional macro VOTER_MIN_CONF_EN: winners below MIN_CONF votes are reported as no-class (11).
module class_decision_voter #(
    parameter int WINDOW   = 8,
    parameter int MIN_CONF = 5,
    parameter int CLASS_W  = 2,
    localparam int CNT_W   = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               class_valid,
    input  logic [CLASS_W-1:0] class_code,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [CLASS_W-1:0] out_class,
    output logic [CNT_W-1:0]   out_conf,
    output logic               overrun
);

    localparam int NUM_CLASSES = 3;

`ifdef VOTER_MIN_CONF_EN
    localparam int CONF_FLOOR = MIN_CONF;
`else
    localparam int CONF_FLOOR = (MIN_CONF < 0) ? MIN_CONF : 0;
`endif

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DECIDE  = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   count [NUM_CLASSES];
    logic [CLASS_W-1:0] win_class;
    logic [CNT_W-1:0]   win_cnt;
    logic [CLASS_W-1:0] dec_class;

    // Strictly-greater scan from code 0 upward keeps ties on the lowest code;
    // an empty tally leaves the no-class code with a zero count.
    always_comb begin
        win_class = '1;
        win_cnt   = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (count[i] > win_cnt) begin
                win_cnt   = count[i];
                win_class = CLASS_W'(i);
            end
        end
    end

    always_comb begin
        dec_class = win_class;
        if (int'(win_cnt) < CONF_FLOOR) begin
            dec_class = '1;
        end
    end

    // Handshake: a decision is transferred on a rising clk edge where out_valid
    // and out_ready are both 1; out_valid/out_class/out_conf are held until then,
    // and out_ready is ignored while out_valid is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            sample_cnt <= '0;
            count      <= '{default: '0};
            out_valid  <= 1'b0;
            out_class  <= '0;
            out_conf   <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (class_valid) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            if (class_code == CLASS_W'(i)) begin
                                count[i] <= count[i] + CNT_W'(1);
                            end
                        end
                        if (sample_cnt == CNT_W'(WINDOW - 1)) begin
                            state <= DECIDE;
                        end
                    end
                end
                DECIDE: begin
                    if (class_valid) begin
                        overrun <= 1'b1;
                    end
                    out_class <= dec_class;
                    out_conf  <= win_cnt;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    // Samples arriving here, including on the handshake edge, are lost.
                    if (class_valid) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        sample_cnt <= '0;
                        count      <= '{default: '0};
                        state      <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
